// File: rtl/gtf_rxlock_pkg.sv
// gtf_rxlock_pkg: shared constants for the GTF RX marker lock stage.
// State encoding, stats counter widths, default lock/unlock thresholds.
package gtf_rxlock_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2,
    RSVD   = 2'd3
  } lock_st_e;

  localparam int unsigned MISS_W = 16;
  localparam int unsigned LOSS_W = 8;

  localparam int unsigned LOCK_CNT_DEF   = 4;
  localparam int unsigned UNLOCK_CNT_DEF = 3;

endpackage

// File: rtl/gtf_sat_cnt.sv
// gtf_sat_cnt: W-bit saturating incrementer, sync active-low clear.
// Ports: clk, clr_n (clear), inc (count enable), cnt (count, holds at all-ones).
module gtf_sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      cnt <= '0;
    end else if (inc && !(&cnt)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/gtf_ch_rxmarker_lock.sv
// gtf_ch_rxmarker_lock: confirms periodic sync markers, declares/drops lock.
// In: gtf_rxusrclk2_out, gtwiz_reset_rx_sync_n, sync_det_in, rxrawdata_in.
// Out: rxrawdata_out, marker_valid, locked, lock_state, miss_cnt,
//      spurious_cnt, lock_loss_cnt (stats need GTF_RXLOCK_STATS_EN, else 0).
module gtf_ch_rxmarker_lock
  import gtf_rxlock_pkg::*;
#(
  parameter int unsigned MARKER_PERIOD = 64,
  parameter int unsigned LOCK_CNT      = LOCK_CNT_DEF,
  parameter int unsigned UNLOCK_CNT    = UNLOCK_CNT_DEF
) (
  input  logic              gtf_rxusrclk2_out,
  input  logic              gtwiz_reset_rx_sync_n,
  input  logic              sync_det_in,
  input  logic [15:0]       rxrawdata_in,
  output logic [15:0]       rxrawdata_out,
  output logic              marker_valid,
  output logic              locked,
  output logic [1:0]        lock_state,
  output logic [MISS_W-1:0] miss_cnt,
  output logic [MISS_W-1:0] spurious_cnt,
  output logic [LOSS_W-1:0] lock_loss_cnt
);

  localparam int unsigned PW =
    (MARKER_PERIOD > 1) ? $clog2(MARKER_PERIOD) : 1;
  localparam logic [PW-1:0] LAST = PW'(MARKER_PERIOD - 1);
  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
  localparam logic [3:0] UNLK_N = 4'(UNLOCK_CNT);

  lock_st_e      st_q, st_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [3:0]    good_q, good_d;
  logic [3:0]    bad_q, bad_d;
  logic          slot;
  logic          hit;
  logic          mv_d;

  assign slot = (ph_q == LAST);
  assign hit  = slot && sync_det_in;

  always_ff @(posedge gtf_rxusrclk2_out) begin
    if (!gtwiz_reset_rx_sync_n) begin
      st_q   <= HUNT;
      ph_q   <= '0;
      good_q <= '0;
      bad_q  <= '0;
    end else begin
      st_q   <= st_d;
      ph_q   <= ph_d;
      good_q <= good_d;
      bad_q  <= bad_d;
    end
  end

  // Phase free-runs modulo the period; only HUNT/VERIFY re-reference it.
  always_comb begin
    st_d   = st_q;
    good_d = good_q;
    bad_d  = bad_q;
    ph_d   = slot ? '0 : ph_q + PW'(1);
    case (st_q)
      HUNT: begin
        if (sync_det_in) begin
          st_d   = VERIFY;
          ph_d   = '0;
          good_d = 4'd1;
        end
      end
      VERIFY: begin
        if (hit) begin
          good_d = good_q + 4'd1;
          if (good_q + 4'd1 == LOCK_N) begin
            st_d  = LOCKED;
            bad_d = '0;
          end
        end else if (sync_det_in) begin
          ph_d   = '0;
          good_d = 4'd1;
        end else if (slot) begin
          st_d = HUNT;
        end
      end
      LOCKED: begin
        if (hit) begin
          bad_d = '0;
        end else if (slot) begin
          bad_d = bad_q + 4'd1;
          if (bad_q + 4'd1 == UNLK_N) begin
            st_d = HUNT;
          end
        end
      end
      default: st_d = HUNT;
    endcase
  end

  always_comb begin
    mv_d = (st_q == LOCKED) && hit;
  end

  assign locked     = (st_q == LOCKED);
  assign lock_state = st_q;

  always_ff @(posedge gtf_rxusrclk2_out) begin
    if (!gtwiz_reset_rx_sync_n) begin
      marker_valid  <= 1'b0;
      rxrawdata_out <= '0;
    end else begin
      marker_valid  <= mv_d;
      rxrawdata_out <= rxrawdata_in;
    end
  end

`ifdef GTF_RXLOCK_STATS_EN
  logic in_lk;
  logic miss_ev;
  logic spur_ev;
  logic loss_ev;

  assign in_lk   = (st_q == LOCKED);
  assign miss_ev = in_lk && slot && !sync_det_in;
  assign spur_ev = in_lk && !slot && sync_det_in;
  assign loss_ev = miss_ev && (bad_q + 4'd1 == UNLK_N);

  gtf_sat_cnt #(.W(MISS_W)) u_miss (
    .clk   (gtf_rxusrclk2_out),
    .clr_n (gtwiz_reset_rx_sync_n),
    .inc   (miss_ev),
    .cnt   (miss_cnt)
  );

  gtf_sat_cnt #(.W(MISS_W)) u_spur (
    .clk   (gtf_rxusrclk2_out),
    .clr_n (gtwiz_reset_rx_sync_n),
    .inc   (spur_ev),
    .cnt   (spurious_cnt)
  );

  gtf_sat_cnt #(.W(LOSS_W)) u_loss (
    .clk   (gtf_rxusrclk2_out),
    .clr_n (gtwiz_reset_rx_sync_n),
    .inc   (loss_ev),
    .cnt   (lock_loss_cnt)
  );
`else
  assign miss_cnt      = '0;
  assign spurious_cnt  = '0;
  assign lock_loss_cnt = '0;
`endif

endmodule
